// File: rtl/when_suite_pulse_monitor.sv
// Pulse monitor for the when-chain output line: measures each high pulse
// (length in cycles, running index) and queues one report record per pulse
// in a small in-order FIFO drained over a valid/ready port.
module when_suite_pulse_monitor #(
   parameter int LEN_W      = 8,
   parameter int CNT_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             io_in,
   input  logic             io_clear,
   input  logic             io_rpt_ready,
   output logic             io_rpt_valid,
   output logic [LEN_W-1:0] io_rpt_len,
   output logic [CNT_W-1:0] io_rpt_idx,
   output logic [CNT_W-1:0] io_pulse_count,
   output logic             io_drop,
   output logic             io_busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [LEN_W-1:0] LEN_MAX = '1;

   // SKIP discards a pulse already high when measurement (re)starts
   typedef enum logic [1:0] {SKIP, IDLE, HIGH} state_t;

   state_t           state;
   logic [LEN_W-1:0] len;
   logic [CNT_W-1:0] count;
   logic             drop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   logic [AW:0]      wr_ptr, rd_ptr;
   logic [LEN_W-1:0] mem_len [FIFO_DEPTH];
   logic [CNT_W-1:0] mem_idx [FIFO_DEPTH];

   logic empty, full, push, pop, wr_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // A record is produced on the edge that samples the falling line
   assign push  = (state == HIGH) && !io_in && !io_clear;
   assign pop   = !empty && io_rpt_ready && !io_clear;
   // A full FIFO still accepts the push when the head leaves on the same edge
   assign wr_en = push && (!full || pop);

   // Control state, counters and FIFO pointers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= SKIP;
         len    <= '0;
         count  <= '0;
         drop   <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (io_clear) begin
         // Clear beats everything; a pulse in progress is abandoned
         state  <= io_in ? SKIP : IDLE;
         len    <= '0;
         count  <= '0;
         drop   <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         case (state)
            SKIP: if (!io_in) state <= IDLE;
            IDLE: if (io_in) begin
               state <= HIGH;
               len   <= {{(LEN_W-1){1'b0}}, 1'b1};
            end
            HIGH: if (io_in) begin
               if (len != LEN_MAX) len <= len + 1'b1;
            end else begin
               count <= count + 1'b1;
               state <= IDLE;
            end
            default: state <= SKIP;
         endcase
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         if (push && full && !pop) drop <= 1'b1;
      end
   end

   // Record storage; contents are only visible while the FIFO is non-empty
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_len[wr_ptr[AW-1:0]] <= len;
         mem_idx[wr_ptr[AW-1:0]] <= count;
      end
   end

   assign io_rpt_valid   = !empty;
   assign io_rpt_len     = empty ? '0 : mem_len[rd_ptr[AW-1:0]];
   assign io_rpt_idx     = empty ? '0 : mem_idx[rd_ptr[AW-1:0]];
   assign io_pulse_count = count;
   assign io_drop        = drop;
   assign io_busy        = (state == HIGH);

endmodule

// File: tb/tb_when_suite_pulse_monitor.sv
// Directed bench for when_suite_pulse_monitor: inputs change 1 time unit
// after a rising edge, outputs are checked there as well.
module tb_when_suite_pulse_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic        io_in, io_clear, io_rpt_ready;
   logic        io_rpt_valid, io_drop, io_busy;
   logic [7:0]  io_rpt_len;
   logic [15:0] io_rpt_idx, io_pulse_count;

   int n_assert = 0;
   int n_fail   = 0;

   when_suite_pulse_monitor #(.LEN_W(8), .CNT_W(16), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .io_in(io_in), .io_clear(io_clear),
      .io_rpt_ready(io_rpt_ready), .io_rpt_valid(io_rpt_valid),
      .io_rpt_len(io_rpt_len), .io_rpt_idx(io_rpt_idx),
      .io_pulse_count(io_pulse_count), .io_drop(io_drop), .io_busy(io_busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_head(input string tag, input int len, input int idx);
      chk({tag, "_valid"}, {31'd0, io_rpt_valid}, 32'd1);
      chk({tag, "_len"}, {24'd0, io_rpt_len}, len);
      chk({tag, "_idx"}, {16'd0, io_rpt_idx}, idx);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, {31'd0, io_rpt_valid}, 32'd0);
      chk({tag, "_busy"},  {31'd0, io_busy}, 32'd0);
      chk({tag, "_count"}, {16'd0, io_pulse_count}, 32'd0);
      chk({tag, "_drop"},  {31'd0, io_drop}, 32'd0);
      chk({tag, "_len"},   {24'd0, io_rpt_len}, 32'd0);
      chk({tag, "_idx"},   {16'd0, io_rpt_idx}, 32'd0);
   endtask

   task automatic do_clear();
      io_in = 1'b0; io_clear = 1'b1;
      tick();
      io_clear = 1'b0;
   endtask

   initial begin
      reset = 1'b1; io_in = 1'b0; io_clear = 1'b0; io_rpt_ready = 1'b1;
      tick(); tick();
      chk_zero("reset");
      reset = 1'b0;

      // 1: basic 3-cycle pulse, busy exactly 3 cycles
      tick(); tick();
      chk("t1_idle_busy", {31'd0, io_busy}, 32'd0);
      io_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t1_busy_high", {31'd0, io_busy}, 32'd1);
      end
      io_in = 1'b0;
      tick();
      chk("t1_busy_low", {31'd0, io_busy}, 32'd0);
      chk_head("t1_rec", 3, 0);
      chk("t1_count", {16'd0, io_pulse_count}, 32'd1);
      tick();
      chk("t1_popped", {31'd0, io_rpt_valid}, 32'd0);

      // 2: five 1-cycle pulses into a 4-deep FIFO, nothing drained
      io_rpt_ready = 1'b0;
      do_clear();
      chk("t2_clr_count", {16'd0, io_pulse_count}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         io_in = 1'b1; tick();
         io_in = 1'b0; tick();
      end
      chk("t2_count", {16'd0, io_pulse_count}, 32'd5);
      chk("t2_drop", {31'd0, io_drop}, 32'd1);
      io_rpt_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk_head("t2_pop", 1, i);
         tick();
      end
      chk("t2_empty", {31'd0, io_rpt_valid}, 32'd0);
      chk("t2_drop_sticky", {31'd0, io_drop}, 32'd1);

      // 3: 300-cycle pulse saturates the 8-bit length
      do_clear();
      chk("t3_clr_drop", {31'd0, io_drop}, 32'd0);
      io_in = 1'b1;
      repeat (300) tick();
      chk("t3_busy", {31'd0, io_busy}, 32'd1);
      io_in = 1'b0;
      tick();
      chk_head("t3_rec", 255, 0);
      chk("t3_count", {16'd0, io_pulse_count}, 32'd1);
      tick();
      chk("t3_popped", {31'd0, io_rpt_valid}, 32'd0);

      // 4: clear on the 2nd high cycle aborts the pulse
      io_in = 1'b1; tick();
      chk("t4_busy", {31'd0, io_busy}, 32'd1);
      io_clear = 1'b1; tick();
      io_clear = 1'b0;
      repeat (4) tick();
      chk("t4_skip_busy", {31'd0, io_busy}, 32'd0);
      chk("t4_skip_count", {16'd0, io_pulse_count}, 32'd0);
      chk("t4_skip_valid", {31'd0, io_rpt_valid}, 32'd0);
      io_in = 1'b0; tick();
      io_in = 1'b1; tick(); tick();
      io_in = 1'b0; tick();
      chk_head("t4_rec", 2, 0);
      chk("t4_count", {16'd0, io_pulse_count}, 32'd1);
      tick();

      // 5: full FIFO, push and pop on the same edge
      io_rpt_ready = 1'b0;
      do_clear();
      for (int i = 0; i < 4; i++) begin
         io_in = 1'b1;
         repeat (i + 1) tick();
         io_in = 1'b0; tick();
      end
      chk("t5_full_count", {16'd0, io_pulse_count}, 32'd4);
      chk_head("t5_head", 1, 0);
      io_in = 1'b1;
      repeat (5) tick();
      io_in = 1'b0; io_rpt_ready = 1'b1;
      tick();
      chk("t5_drop", {31'd0, io_drop}, 32'd0);
      chk("t5_count", {16'd0, io_pulse_count}, 32'd5);
      for (int i = 1; i < 5; i++) begin
         chk_head("t5_pop", i + 1, i);
         tick();
      end
      chk("t5_empty", {31'd0, io_rpt_valid}, 32'd0);

      // 6: async reset mid-pulse, line held high through release
      io_rpt_ready = 1'b0;
      do_clear();
      io_in = 1'b1; tick(); tick();
      io_in = 1'b0; tick();
      chk("t6_pre_valid", {31'd0, io_rpt_valid}, 32'd1);
      io_in = 1'b1; tick();
      chk("t6_pre_busy", {31'd0, io_busy}, 32'd1);
      reset = 1'b1;
      #1;
      chk_zero("t6_async");
      #2 reset = 1'b0;
      repeat (3) tick();
      chk("t6_skip_busy", {31'd0, io_busy}, 32'd0);
      io_in = 1'b0; tick();
      chk("t6_skip_count", {16'd0, io_pulse_count}, 32'd0);
      chk("t6_skip_valid", {31'd0, io_rpt_valid}, 32'd0);
      io_in = 1'b1; repeat (3) tick();
      io_in = 1'b0; tick();
      chk_head("t6_rec", 3, 0);
      chk("t6_count", {16'd0, io_pulse_count}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
